timer_wb_regs: RTL and testbench
================================

# timer_wb_regs

Bus-side register bank and Wishbone classic slave that sits directly upstream of the PWM/timer/counter core. It decodes single-cycle Wishbone accesses, holds the HRC, LRC and CTRL registers that drive the core, and turns counter writes into a one-cycle load strobe with data. It also reads back the live counter and latches the core's interrupt pulse into a sticky, software-clearable status bit that drives the system interrupt line.

## Interface
- ADDR_W, 5: width of the byte address `wb_adr_i`. The four registers occupy byte offsets 0x00, 0x04, 0x08 and 0x0C; bits [1:0] are ignored.
- i_clk  in  1  system clock
- i_rst  in  1  reset, asynchronous, active-high
- wb_cyc_i  in  1  bus cycle valid
- wb_stb_i  in  1  strobe
- wb_we_i  in  1  1 = write
- wb_adr_i  in  ADDR_W  byte address
- wb_sel_i  in  4  byte enables; bit n covers data bits [8n+7:8n]
- wb_dat_i  in  32  write data
- wb_dat_o  out  32  read data, valid while wb_ack_o = 1
- wb_ack_o  out  1  access acknowledge
- timer_cntr_Reg  in  32  live counter value from the core
- timer_int_i  in  1  interrupt pulse from the core
- timer_cntr_Reg_sel  out  1  one-cycle counter load strobe to the core
- wb_data_reg_out  out  32  counter load data to the core
- timer_hrc_Reg  out  32  HI reference register
- timer_lrc_Reg  out  32  LO reference register
- timer_ctrl_Reg  out  9  control register
- irq_o  out  1  system interrupt = CTRL[INT] & CTRL[INTE]

## Operation
- Register map:
  - 0x00 CNTR: read returns `timer_cntr_Reg`; a write loads the counter.
  - 0x04 HRC: read/write.
  - 0x08 LRC: read/write.
  - 0x0C CTRL: read/write, bits [8:0]; bits [31:9] read as 0.
- Any other offset reads 0, ignores writes and is still acknowledged. No error is signalled.
- CTRL bits:
  - EN = 0, ECLK = 1, NEC = 2, OE = 3, SINGLE = 4.
  - INTE = 5, INT = 6, CNTRRST = 7, CAPTE = 8.
  - This block only stores these bits. Their meaning is implemented in the core.
- CTRL[INT] is a sticky status bit:
  - It is set on every clock edge where `timer_int_i` = 1.
  - Writing 1 to bit 6 with wb_sel_i[0] = 1 clears it. Writing 0 leaves it unchanged.
  - If the set and the clear occur in the same cycle, the set wins.
- Byte enables apply to every register. Unselected bytes keep their old value.
- A CNTR write with partial byte enables merges `wb_dat_i` with the current `timer_cntr_Reg` to form `wb_data_reg_out`.
- Access FSM, two states:
  - IDLE: when wb_cyc_i & wb_stb_i = 1, accept the access, perform the register write or read capture, and go to ACK.
  - ACK: wb_ack_o = 1 for exactly one cycle, then return to IDLE unconditionally.
  - While in ACK the block ignores stb, so a held strobe produces one ack every second cycle.
  - If cyc drops while in ACK, the ack is still issued and the master ignores it.

## Timing
- Reset values:
  - wb_ack_o = 0, wb_dat_o = 0, irq_o = 0.
  - timer_cntr_Reg_sel = 0, wb_data_reg_out = 0.
  - timer_hrc_Reg = 0, timer_lrc_Reg = 0, timer_ctrl_Reg = 0.
  - FSM in IDLE.
- Access latency is one wait state:
  - Accept at edge N.
  - wb_ack_o and wb_dat_o are valid in cycle N+1.
- Register writes take effect at edge N, so the core sees new HRC, LRC and CTRL values from cycle N+1.
- A read captures its data at edge N. CNTR read data is the counter value sampled at edge N, not the value during the ack cycle.
- CNTR write timing:
  - timer_cntr_Reg_sel and wb_data_reg_out are registered at edge N.
  - timer_cntr_Reg_sel is high for cycle N+1 only.
  - The core loads the value at edge N+1.
- irq_o is combinational from registered bits and has no extra latency beyond the INT register.
- Asynchronous reset in ACK returns the FSM to IDLE and drops wb_ack_o immediately. An aborted write still keeps any register update made at the accept edge.

## Structure
- Package `timer_pkg` holds:
  - the offset constants REG_CNTR, REG_HRC, REG_LRC, REG_CTRL;
  - the CTRL bit index constants;
  - the FSM state enum.
- The existing timer defines header maps its CTRL indices onto this package.
- One natural sub-module: `wb_byte_merge`, a combinational 32-bit byte-enable merge of old and new data. It is shared by the HRC, LRC, CTRL and CNTR paths.
- The top level `timer_subsys` instantiates timer_wb_regs and the core side by side. That top is out of scope here.

## Test plan
- Reset, then read all four offsets -> each returns 0; each ack is 1 cycle wide and comes 1 cycle after stb.
- Write HRC = 0xDEADBEEF with sel = 0b0101, then read HRC -> 0x00AD00EF.
- With timer_cntr_Reg = 0x11223344, write CNTR with data 0xAABBCCDD and sel = 0b1000 -> wb_data_reg_out = 0xAA223344; timer_cntr_Reg_sel = 1 for exactly one cycle, in the ack cycle.
- Pulse timer_int_i with INTE = 1 -> CTRL[INT] = 1 and irq_o = 1 next cycle. Write 0x40 to CTRL with sel[0] = 1 -> INT = 0 and irq_o = 0. Repeat the clear in the same cycle as a timer_int_i pulse -> INT stays 1.
- Hold cyc/stb high for 6 cycles reading LRC -> exactly 3 acks on alternate cycles; read offset 0x10 -> 0 and acked.
- Assert i_rst during the ACK cycle of a CTRL write -> ack drops immediately, all registers return to 0, and the next access completes normally.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared constants and types for the timer Wishbone register bank.
// Offsets are byte addresses; CTRL indices are also used by the timer core.
package timer_pkg;

  localparam logic [7:0] REG_CNTR = 8'h00;
  localparam logic [7:0] REG_HRC  = 8'h04;
  localparam logic [7:0] REG_LRC  = 8'h08;
  localparam logic [7:0] REG_CTRL = 8'h0C;

  localparam int CTRL_W       = 9;
  localparam int CTRL_EN      = 0;
  localparam int CTRL_ECLK    = 1;
  localparam int CTRL_NEC     = 2;
  localparam int CTRL_OE      = 3;
  localparam int CTRL_SINGLE  = 4;
  localparam int CTRL_INTE    = 5;
  localparam int CTRL_INT     = 6;
  localparam int CTRL_CNTRRST = 7;
  localparam int CTRL_CAPTE   = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } wbState_e;

endpackage

// File: rtl/timer_wb_regs_if.sv
// Wishbone classic bus bundle between a bus master and the timer register bank.
interface timer_wb_regs_if #(
  parameter int ADDR_W = 5
);

  logic              wb_cyc_i;
  logic              wb_stb_i;
  logic              wb_we_i;
  logic [ADDR_W-1:0] wb_adr_i;
  logic [3:0]        wb_sel_i;
  logic [31:0]       wb_dat_i;
  logic [31:0]       wb_dat_o;
  logic              wb_ack_o;

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    output wb_dat_o, wb_ack_o
  );

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o
  );

endinterface

// File: rtl/wb_byte_merge.sv
// Byte-enable merge: each selected byte comes from the new data, the rest
// keep the old value.
module wb_byte_merge (
  input  logic [31:0] old_i,
  input  logic [31:0] new_i,
  input  logic [3:0]  sel_i,
  output logic [31:0] merged_o
);

  for (genvar b = 0; b < 4; b++) begin : g_byte
    assign merged_o[8*b +: 8] = sel_i[b] ? new_i[8*b +: 8] : old_i[8*b +: 8];
  end

endmodule

// File: rtl/timer_wb_regs.sv
// Wishbone classic slave holding the timer HRC/LRC/CTRL registers, the
// counter load strobe and the sticky interrupt status bit.
module timer_wb_regs
  import timer_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic               i_clk,
  input  logic               i_rst,
  timer_wb_regs_if.slave     wb,
  input  logic [31:0]        timer_cntr_Reg,
  input  logic               timer_int_i,
  output logic               timer_cntr_Reg_sel,
  output logic [31:0]        wb_data_reg_out,
  output logic [31:0]        timer_hrc_Reg,
  output logic [31:0]        timer_lrc_Reg,
  output logic [CTRL_W-1:0]  timer_ctrl_Reg,
  output logic               irq_o
);

  wbState_e          state_q, state_d;
  logic              ack;
  logic              accept;
  logic              wrAccept;
  logic [7:0]        adrByte;
  logic              hitCntr, hitHrc, hitLrc, hitCtrl;
  logic [31:0]       oldData;
  logic [31:0]       mergedData;
  logic              intClear;

  logic [31:0]       datR_q;
  logic [31:0]       hrc_q, lrc_q;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              cntrSel_q;
  logic [31:0]       cntrLoad_q;

  // Word-align the byte address; the low two bits never select anything.
  assign adrByte  = 8'(wb.wb_adr_i) & 8'hFC;
  assign hitCntr  = (adrByte == REG_CNTR);
  assign hitHrc   = (adrByte == REG_HRC);
  assign hitLrc   = (adrByte == REG_LRC);
  assign hitCtrl  = (adrByte == REG_CTRL);

  assign accept   = (state_q == ST_IDLE) && wb.wb_cyc_i && wb.wb_stb_i;
  assign wrAccept = accept && wb.wb_we_i;

  // The same mux feeds read data and the old side of the byte merge.
  always_comb begin
    oldData = '0;
    if (hitCntr)      oldData = timer_cntr_Reg;
    else if (hitHrc)  oldData = hrc_q;
    else if (hitLrc)  oldData = lrc_q;
    else if (hitCtrl) oldData = {{(32-CTRL_W){1'b0}}, ctrl_q};
  end

  wb_byte_merge u_merge (
    .old_i    (oldData),
    .new_i    (wb.wb_dat_i),
    .sel_i    (wb.wb_sel_i),
    .merged_o (mergedData)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // ACK lasts exactly one cycle and ignores the strobe.
  always_comb begin
    state_d = state_q;
    ack     = 1'b0;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_ACK;
      ST_ACK: begin
        ack     = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // INT is write-1-to-clear through byte 0; a simultaneous core pulse wins.
  assign intClear = wrAccept && hitCtrl && wb.wb_sel_i[0] && wb.wb_dat_i[CTRL_INT];

  always_comb begin
    ctrl_d = ctrl_q;
    if (wrAccept && hitCtrl) ctrl_d = mergedData[CTRL_W-1:0];
    ctrl_d[CTRL_INT] = timer_int_i | (ctrl_q[CTRL_INT] & ~intClear);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      datR_q     <= '0;
      hrc_q      <= '0;
      lrc_q      <= '0;
      ctrl_q     <= '0;
      cntrSel_q  <= 1'b0;
      cntrLoad_q <= '0;
    end else begin
      if (accept) datR_q <= wb.wb_we_i ? 32'h0 : oldData;
      if (wrAccept && hitHrc) hrc_q <= mergedData;
      if (wrAccept && hitLrc) lrc_q <= mergedData;
      ctrl_q    <= ctrl_d;
      cntrSel_q <= wrAccept && hitCntr;
      if (wrAccept && hitCntr) cntrLoad_q <= mergedData;
    end
  end

  assign wb.wb_ack_o        = ack;
  assign wb.wb_dat_o        = datR_q;
  assign timer_cntr_Reg_sel = cntrSel_q;
  assign wb_data_reg_out    = cntrLoad_q;
  assign timer_hrc_Reg      = hrc_q;
  assign timer_lrc_Reg      = lrc_q;
  assign timer_ctrl_Reg     = ctrl_q;
  assign irq_o              = ctrl_q[CTRL_INT] & ctrl_q[CTRL_INTE];

endmodule

// File: tb/tb_timer_wb_regs.sv
// Directed self-checking bench for timer_wb_regs with hand-computed expectations.
module tb_timer_wb_regs;

  logic        i_clk;
  logic        i_rst;
  logic [31:0] timer_cntr_Reg;
  logic        timer_int_i;
  logic        timer_cntr_Reg_sel;
  logic [31:0] wb_data_reg_out;
  logic [31:0] timer_hrc_Reg;
  logic [31:0] timer_lrc_Reg;
  logic [8:0]  timer_ctrl_Reg;
  logic        irq_o;

  int compCount = 0;
  int failCount = 0;

  timer_wb_regs_if #(.ADDR_W(5)) wb ();

  timer_wb_regs #(.ADDR_W(5)) dut (
    .i_clk              (i_clk),
    .i_rst              (i_rst),
    .wb                 (wb),
    .timer_cntr_Reg     (timer_cntr_Reg),
    .timer_int_i        (timer_int_i),
    .timer_cntr_Reg_sel (timer_cntr_Reg_sel),
    .wb_data_reg_out    (wb_data_reg_out),
    .timer_hrc_Reg      (timer_hrc_Reg),
    .timer_lrc_Reg      (timer_lrc_Reg),
    .timer_ctrl_Reg     (timer_ctrl_Reg),
    .irq_o              (irq_o)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic cyc, input logic stb, input logic we,
                               input logic [4:0] adr, input logic [3:0] sel,
                               input logic [31:0] dat);
    wb.wb_cyc_i = cyc;
    wb.wb_stb_i = stb;
    wb.wb_we_i  = we;
    wb.wb_adr_i = adr;
    wb.wb_sel_i = sel;
    wb.wb_dat_i = dat;
  endtask

  // Called just after a rising edge with the bus idle; returns likewise.
  task automatic wbWrite(input string tag, input logic [7:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic intPulse);
    checkOutput({tag, "_ackPre"}, 32'(wb.wb_ack_o), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, adr[4:0], sel, dat);
    timer_int_i = intPulse;
    @(posedge i_clk); #1;
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 4'd0, 32'd0);
    timer_int_i = 1'b0;
    @(negedge i_clk);
    checkOutput({tag, "_ack"}, 32'(wb.wb_ack_o), 32'd1);
    @(posedge i_clk); #1;
    checkOutput({tag, "_ackEnd"}, 32'(wb.wb_ack_o), 32'd0);
  endtask

  task automatic wbRead(input string tag, input logic [7:0] adr, input logic [31:0] expected);
    checkOutput({tag, "_ackPre"}, 32'(wb.wb_ack_o), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, adr[4:0], 4'hF, 32'd0);
    @(posedge i_clk); #1;
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 4'd0, 32'd0);
    @(negedge i_clk);
    checkOutput({tag, "_ack"}, 32'(wb.wb_ack_o), 32'd1);
    checkOutput({tag, "_data"}, wb.wb_dat_o, expected);
    @(posedge i_clk); #1;
    checkOutput({tag, "_ackEnd"}, 32'(wb.wb_ack_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [5:0] ackPat;
    int         ackCnt;

    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 4'd0, 32'd0);
    i_rst          = 1'b1;
    timer_int_i    = 1'b0;
    timer_cntr_Reg = 32'h0;
    repeat (3) @(posedge i_clk);
    #1 i_rst = 1'b0;

    @(negedge i_clk);
    checkOutput("rst_ack",   32'(wb.wb_ack_o), 32'd0);
    checkOutput("rst_dat",   wb.wb_dat_o, 32'd0);
    checkOutput("rst_irq",   32'(irq_o), 32'd0);
    checkOutput("rst_sel",   32'(timer_cntr_Reg_sel), 32'd0);
    checkOutput("rst_load",  wb_data_reg_out, 32'd0);
    checkOutput("rst_hrc",   timer_hrc_Reg, 32'd0);
    checkOutput("rst_lrc",   timer_lrc_Reg, 32'd0);
    checkOutput("rst_ctrl",  32'(timer_ctrl_Reg), 32'd0);
    @(posedge i_clk); #1;

    wbRead("rd0_cntr", 8'h00, 32'h0);
    wbRead("rd0_hrc",  8'h04, 32'h0);
    wbRead("rd0_lrc",  8'h08, 32'h0);
    wbRead("rd0_ctrl", 8'h0C, 32'h0);

    wbWrite("wr_hrc", 8'h04, 32'hDEADBEEF, 4'b0101, 1'b0);
    checkOutput("hrc_out", timer_hrc_Reg, 32'h00AD00EF);
    wbRead("rd_hrc", 8'h04, 32'h00AD00EF);
    wbWrite("wr_lrc", 8'h08, 32'h12345678, 4'b1111, 1'b0);
    wbRead("rd_lrc", 8'h08, 32'h12345678);
    wbRead("rd_lrcLo", 8'h0B, 32'h12345678);

    // Partial counter write merges with the live counter at the accept edge.
    timer_cntr_Reg = 32'h11223344;
    applyStimulus(1'b1, 1'b1, 1'b1, 5'h00, 4'b1000, 32'hAABBCCDD);
    #2 checkOutput("cntr_selPre", 32'(timer_cntr_Reg_sel), 32'd0);
    @(posedge i_clk); #1;
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 4'd0, 32'd0);
    timer_cntr_Reg = 32'h55667788;
    @(negedge i_clk);
    checkOutput("cntr_ack",  32'(wb.wb_ack_o), 32'd1);
    checkOutput("cntr_sel",  32'(timer_cntr_Reg_sel), 32'd1);
    checkOutput("cntr_load", wb_data_reg_out, 32'hAA223344);
    @(posedge i_clk); #1;
    checkOutput("cntr_selEnd", 32'(timer_cntr_Reg_sel), 32'd0);
    checkOutput("cntr_loadHold", wb_data_reg_out, 32'hAA223344);

    // CNTR read data is the value at the accept edge, not during ack.
    timer_cntr_Reg = 32'h0BADF00D;
    applyStimulus(1'b1, 1'b1, 1'b0, 5'h00, 4'hF, 32'd0);
    @(posedge i_clk); #1;
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 4'd0, 32'd0);
    timer_cntr_Reg = 32'h12345678;
    @(negedge i_clk);
    checkOutput("rdCntr_ack",  32'(wb.wb_ack_o), 32'd1);
    checkOutput("rdCntr_data", wb.wb_dat_o, 32'h0BADF00D);
    checkOutput("rdCntr_sel",  32'(timer_cntr_Reg_sel), 32'd0);
    @(posedge i_clk); #1;

    // Sticky interrupt sequence.
    wbWrite("wr_inte", 8'h0C, 32'h20, 4'b0001, 1'b0);
    checkOutput("inte_ctrl", 32'(timer_ctrl_Reg), 32'h020);
    checkOutput("inte_irq",  32'(irq_o), 32'd0);
    timer_int_i = 1'b1;
    @(posedge i_clk); #1;
    timer_int_i = 1'b0;
    checkOutput("int_ctrl", 32'(timer_ctrl_Reg), 32'h060);
    checkOutput("int_irq",  32'(irq_o), 32'd1);
    wbWrite("wr_zero6", 8'h0C, 32'h20, 4'b0001, 1'b0);
    checkOutput("zero6_ctrl", 32'(timer_ctrl_Reg), 32'h060);
    wbWrite("wr_nosel", 8'h0C, 32'h60, 4'b0000, 1'b0);
    checkOutput("nosel_ctrl", 32'(timer_ctrl_Reg), 32'h060);
    wbWrite("wr_clr40", 8'h0C, 32'h40, 4'b0001, 1'b0);
    checkOutput("clr40_ctrl", 32'(timer_ctrl_Reg), 32'h000);
    checkOutput("clr40_irq",  32'(irq_o), 32'd0);
    wbWrite("wr_inte2", 8'h0C, 32'h20, 4'b0001, 1'b1);
    checkOutput("inte2_ctrl", 32'(timer_ctrl_Reg), 32'h060);
    wbWrite("wr_clrRace", 8'h0C, 32'h60, 4'b0001, 1'b1);
    checkOutput("race_ctrl", 32'(timer_ctrl_Reg), 32'h060);
    checkOutput("race_irq",  32'(irq_o), 32'd1);
    wbWrite("wr_clr60", 8'h0C, 32'h60, 4'b0001, 1'b0);
    checkOutput("clr60_ctrl", 32'(timer_ctrl_Reg), 32'h020);
    checkOutput("clr60_irq",  32'(irq_o), 32'd0);
    wbWrite("wr_ctrlAll", 8'h0C, 32'hFFFFFFFF, 4'b1111, 1'b0);
    checkOutput("ctrlAll_ctrl", 32'(timer_ctrl_Reg), 32'h1BF);
    wbRead("rd_ctrlAll", 8'h0C, 32'h000001BF);

    // Held strobe: one ack every second cycle.
    ackCnt = 0;
    ackPat = '0;
    applyStimulus(1'b1, 1'b1, 1'b0, 5'h08, 4'hF, 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(posedge i_clk);
      @(negedge i_clk);
      ackPat[i] = wb.wb_ack_o;
      if (wb.wb_ack_o) begin
        ackCnt++;
        checkOutput("held_data", wb.wb_dat_o, 32'h12345678);
      end
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 4'd0, 32'd0);
    checkOutput("held_count", 32'(ackCnt), 32'd3);
    checkOutput("held_pattern", 32'(ackPat), 32'h15);
    @(posedge i_clk); #1;

    wbRead("rd_unmapped", 8'h10, 32'h0);
    wbWrite("wr_unmapped", 8'h1C, 32'hFFFFFFFF, 4'b1111, 1'b0);
    checkOutput("unm_hrc",  timer_hrc_Reg, 32'h00AD00EF);
    checkOutput("unm_lrc",  timer_lrc_Reg, 32'h12345678);
    checkOutput("unm_ctrl", 32'(timer_ctrl_Reg), 32'h1BF);
    checkOutput("unm_load", wb_data_reg_out, 32'hAA223344);

    // Reset during the ack of a CTRL write.
    applyStimulus(1'b1, 1'b1, 1'b1, 5'h0C, 4'b0001, 32'h21);
    @(posedge i_clk); #1;
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 4'd0, 32'd0);
    checkOutput("abort_ctrl", 32'(timer_ctrl_Reg), 32'h121);
    checkOutput("abort_ack",  32'(wb.wb_ack_o), 32'd1);
    #2 i_rst = 1'b1;
    #1;
    checkOutput("arst_ack",  32'(wb.wb_ack_o), 32'd0);
    checkOutput("arst_hrc",  timer_hrc_Reg, 32'd0);
    checkOutput("arst_lrc",  timer_lrc_Reg, 32'd0);
    checkOutput("arst_ctrl", 32'(timer_ctrl_Reg), 32'd0);
    checkOutput("arst_load", wb_data_reg_out, 32'd0);
    checkOutput("arst_irq",  32'(irq_o), 32'd0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    wbRead("post_rd_hrc", 8'h04, 32'h0);
    wbWrite("post_wr_hrc", 8'h04, 32'h0000_0001, 4'b1111, 1'b0);
    wbRead("post_rd_hrc2", 8'h04, 32'h0000_0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, failCount);
    $finish;
  end

endmodule
